temporizador_parametrico: RTL and testbench
===========================================

# temporizador_parametrico

Programmable bank of NUM_PARAMS traffic-light phase durations (base, extension, yellow, spare) with an integrated countdown timer. The controller FSM selects a phase with `intervalo` and pulses `start`. The block loads the stored duration and counts it down on the 1 Hz `tick` enable, then pulses `expirado`. It replaces the fixed three-register timing store and gives the controller a single timing resource with parametrised width and depth, write validation and status outputs.

## Interface
- WIDTH, 4, bit width of each duration and of the countdown
- NUM_PARAMS, 4, number of duration registers (≤ 2**SEL_W)
- SEL_W, 2, width of the selector and `intervalo` inputs
- DEF_PARAM, 16'h1236, packed reset values; entry i at bits [i*WIDTH +: WIDTH] (tbase=6, text=3, tyel=2, spare=1)

- clk  in  1  system clock; all state on rising edge
- reset_sincrono_n  in  1  synchronous, active-low reset
- time_parameter_selector  in  SEL_W  index of register to reprogram
- time_value  in  WIDTH  new duration value
- reprogram_sincrono  in  1  write strobe, sampled each clk
- intervalo  in  SEL_W  phase index for readback and for `start`
- start  in  1  load selected duration and begin countdown
- tick  in  1  one-cycle count enable (1 Hz strobe)
- valor  out  WIDTH  combinational readback of register[intervalo]; all ones if the index ≥ NUM_PARAMS
- restante  out  WIDTH  remaining count, registered
- busy  out  1  high while in COUNT
- expirado  out  1  one-cycle pulse when a countdown reaches zero
- prog_error  out  1  one-cycle pulse on a rejected write or a rejected start

## Operation
- Reset (reset_sincrono_n=0 at an edge):
  - all registers load their DEF_PARAM entries
  - state goes to IDLE
  - restante=0, busy=0, expirado=0, prog_error=0
  - reset overrides start, tick and reprogram in the same cycle
- Write: reprogram_sincrono=1 with selector < NUM_PARAMS and time_value ≠ 0 updates register[selector] at that edge.
- Rejected write: time_value=0 or selector ≥ NUM_PARAMS. The register is left unchanged and prog_error pulses on the next cycle.
- The write path is independent of the FSM. A write during COUNT changes the register but not the running countdown.
- FSM states: IDLE and COUNT.
  - IDLE, start=1, intervalo valid: restante ← register[intervalo], using the pre-write value if a same-cycle write targets that index. Go to COUNT.
  - IDLE or COUNT, start=1, intervalo ≥ NUM_PARAMS: start is ignored, state is unchanged, prog_error pulses.
  - COUNT, tick=1, restante > 1: restante decrements by 1.
  - COUNT, tick=1, restante = 1: restante ← 0, expirado pulses, go to IDLE.
  - COUNT, start=1 with valid intervalo: restart. restante reloads and start takes priority over tick.
- prog_error is the OR of the write-reject and start-reject conditions in the same cycle. It is a single pulse.
- Decrement is unsigned WIDTH-bit. Stored values are never 0, so restante never wraps.

## Timing
- busy rises on the edge that samples start and stays high until the edge where the count reaches zero.
- A tick in the same cycle as the loading start is ignored. A duration of N therefore takes exactly N subsequent ticks.
- expirado is high for the single cycle after the edge where restante goes 1→0. busy falls on that same edge.
- start in the expirado cycle: new load on that edge, busy re-asserts, no gap needed.
- valor follows intervalo and register contents combinationally. A write is visible on valor in the cycle after its edge.
- Reset in mid-countdown aborts with no expirado pulse.

## Test plan
- Reset then readback: intervalo 0/1/2/3 gives valor 6/3/2/1; busy=0, restante=0.
- Write time_value=9 to selector 0, then start with intervalo=0: restante=9; after 9 ticks expirado pulses once and busy falls; tick 8 leaves restante=1.
- Rejected writes: time_value=0 to selector 2 leaves valor at 2 for intervalo=2 and prog_error pulses once. A write to selector 3 with NUM_PARAMS=3 gives the same result.
- Restart: start on intervalo=1 (3), two ticks, then start on intervalo=2 in the same cycle as a tick: restante=2, and expirado comes after 2 more ticks.
- Same-cycle write and start on index 1 (old 3, new 7): countdown uses 3 and valor reads 7 afterwards. Reset asserted mid-count: restante=0 and no expirado.
- Parameter sweep with WIDTH=6, NUM_PARAMS=8: load 63 and count 63 ticks to expirado with no wrap.

Source files
------------

// File: rtl/temporizador_parametrico.sv
// temporizador_parametrico: programmable bank of phase durations with a tick-driven countdown.
module temporizador_parametrico #(
  parameter int WIDTH = 4,
  parameter int NUM_PARAMS = 4,
  parameter int SEL_W = 2,
  parameter logic [NUM_PARAMS*WIDTH-1:0] DEF_PARAM = 16'h1236
) (
  input  logic             clk,
  input  logic             reset_sincrono_n,
  input  logic [SEL_W-1:0] time_parameter_selector,
  input  logic [WIDTH-1:0] time_value,
  input  logic             reprogram_sincrono,
  input  logic [SEL_W-1:0] intervalo,
  input  logic             start,
  input  logic             tick,
  output logic [WIDTH-1:0] valor,
  output logic [WIDTH-1:0] restante,
  output logic             busy,
  output logic             expirado,
  output logic             prog_error
);
  typedef enum logic {IDLE, COUNT} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] params_q [NUM_PARAMS];
  logic [WIDTH-1:0] params_d [NUM_PARAMS];
  logic [WIDTH-1:0] restante_q, restante_d;
  logic expirado_q, expirado_d, prog_error_q, prog_error_d;
  logic sel_ok, iv_ok, wr_ok, start_ok;
  assign sel_ok = 32'(time_parameter_selector) < NUM_PARAMS;
  assign iv_ok = 32'(intervalo) < NUM_PARAMS;
  assign wr_ok = reprogram_sincrono && sel_ok && time_value != '0;
  assign start_ok = start && iv_ok;
  assign valor = iv_ok ? params_q[intervalo] : '1;
  assign restante = restante_q;
  assign busy = state_q == COUNT;
  assign expirado = expirado_q;
  assign prog_error = prog_error_q;
  always_comb begin
    params_d = params_q;
    if (wr_ok) params_d[time_parameter_selector] = time_value;
    state_d = state_q;
    restante_d = restante_q;
    expirado_d = 1'b0;
    prog_error_d = (reprogram_sincrono && !wr_ok) || (start && !iv_ok);
    // start wins over tick and always loads the pre-write register value
    if (start_ok) begin
      restante_d = params_q[intervalo];
      state_d = COUNT;
    end else if (state_q == COUNT && tick) begin
      restante_d = restante_q - 1'b1;
      expirado_d = restante_q == WIDTH'(1);
      state_d = restante_q == WIDTH'(1) ? IDLE : COUNT;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_sincrono_n) begin
      for (int i = 0; i < NUM_PARAMS; i++) params_q[i] <= DEF_PARAM[i*WIDTH +: WIDTH];
      state_q <= IDLE;
      restante_q <= '0;
      expirado_q <= 1'b0;
      prog_error_q <= 1'b0;
    end else begin
      params_q <= params_d;
      state_q <= state_d;
      restante_q <= restante_d;
      expirado_q <= expirado_d;
      prog_error_q <= prog_error_d;
    end
  end
endmodule

// File: tb/tb_temporizador_parametrico.sv
// tb_temporizador_parametrico: directed checks on default, 3-entry and 6-bit/8-entry instances.
module tb_temporizador_parametrico;
  logic clk = 0, rst_n = 0;
  logic [1:0] sel = 0, iv = 0;
  logic [3:0] tv = 0;
  logic rp = 0, st = 0, tk = 0, rp3 = 0, st3 = 0;
  logic [3:0] valor, restante, valor3, restante3;
  logic busy, expi, perr, busy3, expi3, perr3;
  logic [2:0] sel6 = 0, iv6 = 0;
  logic [5:0] tv6 = 0, valor6, restante6;
  logic rp6 = 0, st6 = 0, tk6 = 0, busy6, expi6, perr6;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  temporizador_parametrico dut (.clk(clk), .reset_sincrono_n(rst_n),
    .time_parameter_selector(sel), .time_value(tv), .reprogram_sincrono(rp),
    .intervalo(iv), .start(st), .tick(tk), .valor(valor), .restante(restante),
    .busy(busy), .expirado(expi), .prog_error(perr));

  temporizador_parametrico #(.NUM_PARAMS(3), .DEF_PARAM(12'h236)) dut3 (.clk(clk),
    .reset_sincrono_n(rst_n), .time_parameter_selector(sel), .time_value(tv),
    .reprogram_sincrono(rp3), .intervalo(iv), .start(st3), .tick(tk), .valor(valor3),
    .restante(restante3), .busy(busy3), .expirado(expi3), .prog_error(perr3));

  temporizador_parametrico #(.WIDTH(6), .NUM_PARAMS(8), .SEL_W(3),
    .DEF_PARAM(48'h041041041041)) dut6 (.clk(clk), .reset_sincrono_n(rst_n),
    .time_parameter_selector(sel6), .time_value(tv6), .reprogram_sincrono(rp6),
    .intervalo(iv6), .start(st6), .tick(tk6), .valor(valor6), .restante(restante6),
    .busy(busy6), .expirado(expi6), .prog_error(perr6));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] defs [4] = '{4'd6, 4'd3, 4'd2, 4'd1};
    cyc(2);
    check("rst_busy", busy, 0);
    check("rst_restante", restante, 0);
    check("rst_expirado", expi, 0);
    check("rst_prog_error", perr, 0);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      iv = 2'(i);
      #1;
      check($sformatf("def_valor%0d", i), valor, defs[i]);
    end
    // full-range countdown on the wide instance
    rp6 = 1; sel6 = 5; tv6 = 63; cyc(); rp6 = 0;
    iv6 = 5; st6 = 1; cyc(); st6 = 0;
    check("w6_load", restante6, 63);
    check("w6_busy", busy6, 1);
    tk6 = 1; cyc(62);
    check("w6_tick62", restante6, 1);
    check("w6_noexp", expi6, 0);
    cyc();
    check("w6_exp", expi6, 1);
    check("w6_zero", restante6, 0);
    check("w6_idle", busy6, 0);
    tk6 = 0;
    // write 9 then count it out
    rp = 1; sel = 0; tv = 9; cyc(); rp = 0;
    iv = 0; #1;
    check("wr_valor", valor, 9);
    check("wr_noerr", perr, 0);
    st = 1; tk = 1; cyc(); st = 0;
    check("ld_restante", restante, 9);
    check("ld_busy", busy, 1);
    cyc(8);
    check("t8_restante", restante, 1);
    check("t8_noexp", expi, 0);
    check("t8_busy", busy, 1);
    cyc();
    check("t9_exp", expi, 1);
    check("t9_busy", busy, 0);
    check("t9_restante", restante, 0);
    tk = 0; cyc();
    check("exp_pulse", expi, 0);
    // rejected writes
    rp = 1; sel = 2; tv = 0; cyc(); rp = 0;
    check("rej0_err", perr, 1);
    iv = 2; #1;
    check("rej0_valor", valor, 2);
    cyc();
    check("rej0_pulse", perr, 0);
    rp3 = 1; sel = 3; tv = 5; cyc(); rp3 = 0;
    check("rej3_err", perr3, 1);
    iv = 3; #1;
    check("rej3_valor_oob", valor3, 15);
    iv = 2; #1;
    check("rej3_valor2", valor3, 2);
    cyc();
    check("rej3_pulse", perr3, 0);
    iv = 3; st3 = 1; cyc(); st3 = 0;
    check("rejst_err", perr3, 1);
    check("rejst_busy", busy3, 0);
    // restart with simultaneous tick
    iv = 1; st = 1; cyc(); st = 0;
    check("rs_load", restante, 3);
    tk = 1; cyc(2);
    check("rs_two", restante, 1);
    iv = 2; st = 1; cyc(); st = 0;
    check("rs_reload", restante, 2);
    check("rs_noexp", expi, 0);
    cyc();
    check("rs_one", restante, 1);
    check("rs_noexp2", expi, 0);
    cyc();
    check("rs_exp", expi, 1);
    check("rs_idle", busy, 0);
    // start in the expirado cycle reloads without a gap
    iv = 3; st = 1; tk = 0; cyc(); st = 0;
    check("back2back_busy", busy, 1);
    check("back2back_restante", restante, 1);
    tk = 1; cyc(); tk = 0;
    check("back2back_exp", expi, 1);
    // same-cycle write and start on index 1
    rp = 1; sel = 1; tv = 7; iv = 1; st = 1; cyc(); rp = 0; st = 0;
    check("sc_restante", restante, 3);
    check("sc_valor", valor, 7);
    tk = 1; cyc(); tk = 0;
    check("sc_tick", restante, 2);
    rst_n = 0; cyc(); rst_n = 1;
    check("ab_restante", restante, 0);
    check("ab_busy", busy, 0);
    check("ab_valor", valor, 3);
    tk = 1; cyc(3); tk = 0;
    check("ab_noexp", expi, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
